add_sub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor, successor to the 8-bit two-group CLA add/sub. The operand width is split into SEG_W-bit segments. Each pipeline stage resolves one segment with 4-bit carry-lookahead groups and registers the carry into the next stage. It adds a valid/ready handshake with full back-pressure, an operation select per transaction, and carry/overflow/zero/negative flags. It sits between operand-fetch and writeback in the datapath, at one result per cycle.

---
 rtl/add_sub_pipe.sv | 128 ++++++++++++
 tb/tb_add_sub_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor. Each stage resolves one SEG_W-bit
// segment with rippled 4-bit CLA groups; the segment carry is registered forward.
module add_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int NSTG = WIDTH / SEG_W;

    // Returns {carry_out, sum} for one segment built from 4-bit lookahead groups.
    function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                               input logic [SEG_W-1:0] y,
                                               input logic             ci);
        logic [SEG_W:0]   c;
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < SEG_W / 4; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
        end
        return {c[SEG_W], p ^ c[SEG_W-1:0]};
    endfunction

    logic [NSTG:0] vld_pipe;
    logic          stall;
    logic          cin_q;
    logic          ov_q;
    logic          ov_d;

    assign stall     = vld_pipe[NSTG] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_pipe[NSTG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            cin_q    <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[NSTG-1:0], in_valid};
            cin_q    <= sub;
        end
    end

    // Stage k owns the operand bits it has not consumed yet (REM wide) and the
    // result bits produced so far (RW wide), so every register bit is used.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int REM = WIDTH - k * SEG_W;
        localparam int RW  = (k + 1) * SEG_W;

        logic [REM-1:0] a_q, bx_q, a_d, bx_d;
        logic [RW-1:0]  res_q, res_d;
        logic           cy_q, cy_d, z_q, z_d;
        logic           ci, zi;
        logic [SEG_W:0] s;

        if (k == 0) begin : g_src
            assign a_d   = a;
            assign bx_d  = b ^ {WIDTH{sub}};
            assign ci    = cin_q;
            assign zi    = 1'b1;
            assign res_d = s[SEG_W-1:0];
        end else begin : g_src
            assign a_d   = g_stg[k-1].a_q[REM+SEG_W-1:SEG_W];
            assign bx_d  = g_stg[k-1].bx_q[REM+SEG_W-1:SEG_W];
            assign ci    = g_stg[k-1].cy_q;
            assign zi    = g_stg[k-1].z_q;
            assign res_d = {s[SEG_W-1:0], g_stg[k-1].res_q};
        end

        assign s    = seg_add(a_q[SEG_W-1:0], bx_q[SEG_W-1:0], ci);
        assign cy_d = s[SEG_W];
        assign z_d  = zi & (s[SEG_W-1:0] == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q   <= '0;
                bx_q  <= '0;
                res_q <= '0;
                cy_q  <= 1'b0;
                z_q   <= 1'b0;
            end else if (!stall) begin
                a_q   <= a_d;
                bx_q  <= bx_d;
                res_q <= res_d;
                cy_q  <= cy_d;
                z_q   <= z_d;
            end
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign ov_d = g_stg[NSTG-1].a_q[SEG_W-1] ^ g_stg[NSTG-1].bx_q[SEG_W-1]
                ^ g_stg[NSTG-1].s[SEG_W-1] ^ g_stg[NSTG-1].s[SEG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ov_q <= 1'b0;
        else if (!stall) ov_q <= ov_d;
    end

    assign result    = g_stg[NSTG-1].res_q;
    assign carry_out = g_stg[NSTG-1].cy_q;
    assign zero      = g_stg[NSTG-1].z_q;
    assign negative  = g_stg[NSTG-1].res_q[WIDTH-1];
    assign overflow  = ov_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe at 16/8, 32/8 and 64/16: expected results
// come from plain integer arithmetic and are checked by a decoupled monitor.
module tb_add_sub_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  in_valid, in_ready, sub, out_valid, out_ready;
    logic [2:0]  carry_out, overflow, zero, negative;
    logic [63:0] a [3];
    logic [63:0] b [3];
    logic [63:0] res [3];
    logic [15:0] r0;
    logic [31:0] r1;
    logic [63:0] r2;
    int          W [3] = '{16, 32, 64};
    int          NS [3] = '{2, 4, 4};

    assign res[0] = {48'b0, r0};
    assign res[1] = {32'b0, r1};
    assign res[2] = r2;

    add_sub_pipe #(.WIDTH(16), .SEG_W(8)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][15:0]), .b(b[0][15:0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(r0), .carry_out(carry_out[0]),
        .overflow(overflow[0]), .zero(zero[0]), .negative(negative[0]));
    add_sub_pipe #(.WIDTH(32), .SEG_W(8)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][31:0]), .b(b[1][31:0]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(r1), .carry_out(carry_out[1]),
        .overflow(overflow[1]), .zero(zero[1]), .negative(negative[1]));
    add_sub_pipe #(.WIDTH(64), .SEG_W(16)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .result(r2), .carry_out(carry_out[2]),
        .overflow(overflow[2]), .zero(zero[2]), .negative(negative[2]));

    int          errs = 0;
    int          chks = 0;
    int          cyc = 0;
    int          nout [3] = '{0, 0, 0};
    int          out_cyc [$];
    logic [67:0] q [3][$];
    logic [2:0]  prev_stall = '0;
    logic [67:0] prev_obs [3];
    logic [2:0]  done = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: unsigned compare for borrow, wide signed sum for overflow.
    function automatic logic [67:0] model(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input logic s);
        logic [63:0] m, r;
        logic [64:0] full;
        logic signed [65:0] sx, sy, t, lim;
        logic c, v;
        m = wmask(w);
        x = x & m;
        y = y & m;
        if (s) begin
            r = (x - y) & m;
            c = (x >= y);
        end else begin
            full = {1'b0, x} + {1'b0, y};
            r = full[63:0] & m;
            c = full[w];
        end
        sx = $signed({2'b00, x});
        sy = $signed({2'b00, y});
        if (x[w-1]) sx = sx - (66'sd1 <<< w);
        if (y[w-1]) sy = sy - (66'sd1 <<< w);
        t   = s ? (sx - sy) : (sx + sy);
        lim = 66'sd1 <<< (w - 1);
        v   = (t >= lim) || (t < -lim);
        return {r, c, v, (r == 64'd0), r[w-1]};
    endfunction

    function automatic logic [67:0] observed(input int i);
        return {res[i] & wmask(W[i]), carry_out[i], overflow[i], zero[i], negative[i]};
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++)
                if (in_valid[i] && in_ready[i])
                    q[i].push_back(model(W[i], a[i], b[i], sub[i]));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (prev_stall[i]) begin
                    chk($sformatf("hold_valid%0d", i), {67'b0, out_valid[i]}, 68'd1);
                    chk($sformatf("hold_data%0d", i), observed(i), prev_obs[i]);
                end
                if (out_valid[i] && !out_ready[i])
                    chk($sformatf("stall_in_ready%0d", i), {67'b0, in_ready[i]}, 68'd0);
                if (out_valid[i] && out_ready[i]) begin
                    nout[i]++;
                    if (i == 0) out_cyc.push_back(cyc);
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_out%0d", i), observed(i), 68'd0 - 68'd1);
                    end else begin
                        chk($sformatf("result%0d", i), observed(i), q[i].pop_front());
                    end
                end
                prev_stall[i] = out_valid[i] & ~out_ready[i];
                prev_obs[i]   = observed(i);
            end
        end else begin
            prev_stall = '0;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int i, input logic [63:0] x, input logic [63:0] y, input logic s);
        int   n;
        logic acc;
        n = 0;
        a[i] = x; b[i] = y; sub[i] = s; in_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready[i];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk($sformatf("accept_timeout%0d", i), 68'd0, 68'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic directed(input string nm, input logic [63:0] x, input logic [63:0] y,
                            input logic s, input logic [67:0] exp);
        int lat;
        send(0, x, y, s);
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk({nm, "_latency"}, 68'(lat), 68'd2);
        chk(nm, observed(0), exp);
        cycles(2);
    endtask

    task automatic rand_stream(input int i, input int n);
        logic [63:0] x, y;
        for (int k = 0; k < n; k++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 15))
                0: x = '0;
                1: y = '0;
                2: y = 64'd1 << (W[i] - 1);
                3: x = '1;
                4: y = x;
                default: ;
            endcase
            send(i, x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin in_valid[i] = 1'b0; cycles(1); end
        end
        in_valid[i] = 1'b0;
        done[i] = 1'b1;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        in_valid = '0; sub = '0; out_ready = '1;
        for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
        cycles(2);
        chk("reset_outputs", {observed(0), out_valid[0], in_ready[0]}, 70'b01);
        rst_n = 1'b1;
        cycles(1);

        directed("add_carry_seg", 64'h00FF, 64'h0001, 1'b0, {64'h0100, 4'b0000});
        directed("sub_most_neg", 64'h0000, 64'h8000, 1'b1, {64'h8000, 4'b0101});
        directed("sub_equal", 64'h1234, 64'h1234, 1'b1, {64'h0000, 4'b1010});

        out_cyc.delete();
        for (int k = 0; k < 8; k++)
            send(0, 64'($urandom), 64'($urandom), 1'(k & 1));
        in_valid[0] = 1'b0;
        cycles(6);
        chk("b2b_count", 68'(out_cyc.size()), 68'd8);
        if (out_cyc.size() == 8) chk("b2b_consecutive", 68'(out_cyc[7] - out_cyc[0]), 68'd7);

        n0 = nout[0];
        out_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) send(0, 64'($urandom), 64'($urandom), 1'(k & 1));
        fork
            send(0, 64'h7FFF, 64'h0001, 1'b0);
            begin
                cycles(5);
                chk("bp_full_in_ready", {67'b0, in_ready[0]}, 68'd0);
                out_ready[0] = 1'b1;
            end
        join
        in_valid[0] = 1'b0;
        cycles(6);
        chk("bp_drain_count", 68'(nout[0] - n0), 68'd4);

        n0 = nout[0];
        send(0, 64'h0011, 64'h0022, 1'b0);
        send(0, 64'h0033, 64'h0044, 1'b1);
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {observed(0), out_valid[0], in_ready[0]}, 70'b01);
        for (int i = 0; i < 3; i++) q[i].delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(6);
        chk("midreset_no_output", 68'(nout[0] - n0), 68'd0);

        fork
            rand_stream(1, 10000);
            rand_stream(2, 10000);
            while (!(done[1] && done[2])) begin
                @(posedge clk); #1;
                out_ready[1] = ($urandom_range(0, 3) != 0);
                out_ready[2] = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = '1;
        for (int t = 0; t < 50 && (q[1].size() + q[2].size()) != 0; t++) cycles(1);
        for (int i = 0; i < 3; i++) chk($sformatf("drained%0d", i), 68'(q[i].size()), 68'd0);
        chk("rand_count32", 68'(nout[1]), 68'd10000);
        chk("rand_count64", 68'(nout[2]), 68'd10000);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
